led_arbiter: RTL and testbench
==============================

LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters sharing the LED bank (2..8).
REQ-002 Parameter HOLD_CYCLES, default 25000000, meaning minimum grant tenure in clk cycles (>=1).
REQ-003 Parameter BITS, default 23, meaning heartbeat counter width (>=8).
REQ-004 Port clk  input  1  single clock for the whole block; 25 MHz board clock.
REQ-005 Port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 Port req  input  N_REQ  per-requester LED request, level-sensitive.
REQ-007 Port req_data  input  8*N_REQ  LED pattern per requester; requester i occupies bits [8i+7:8i].
REQ-008 Port grant  output  N_REQ  one-hot current owner; all-zero when idle.
REQ-009 Port led  output  8  registered LED drive.

Function
REQ-010 Two states, IDLE and OWNED; all outputs are registered.
REQ-011 IDLE: each cycle, if req is nonzero, select the first set bit searching from rr_ptr upward with wrap-around; next cycle state=OWNED, grant=onehot(sel), led=req_data[sel], hold counter=HOLD_CYCLES-1.
REQ-012 Latency: req rising in IDLE -> grant and led valid exactly 1 cycle later.
REQ-013 OWNED with owner req=1: led follows req_data[owner] with 1-cycle latency.
REQ-014 OWNED with owner req=0: led freezes at the last captured pattern; grant stays asserted.
REQ-015 Hold counter decrements by 1 per cycle in OWNED and saturates at 0.
REQ-016 Before the hold counter reaches 0, no other requester can preempt the owner.
REQ-017 At hold=0, if any other req is set, grant moves to the next set bit after the owner (wrap-around) on the following cycle, the hold counter reloads, and there is no IDLE gap.
REQ-018 At hold=0 with no other req: owner req=1 keeps OWNED; owner req=0 returns to IDLE next cycle and sets grant=0.
REQ-019 rr_ptr is set to owner+1 mod N_REQ on every grant; a single persistent requester always retains ownership.
REQ-020 In IDLE, led is driven as defined in REQ-027/REQ-028.
REQ-021 With HOLD_CYCLES=1 the counter loads 0, so arbitration is re-evaluated every cycle.

Reset
REQ-022 rst_n=0 forces state=IDLE, grant=0, led=0, rr_ptr=0, hold counter=0, and heartbeat counter=0, all asynchronously.
REQ-023 Reset deassertion mid-request: the first arbitration happens on the first clk edge with rst_n=1, and grant appears 1 cycle later.
REQ-024 Reset asserted during OWNED drops grant immediately, without waiting for a clock edge.

Configuration
REQ-025 Macro LED_ARBITER_HEARTBEAT_EN selects the idle display.
REQ-026 The heartbeat counter is a BITS-wide free-running up-counter that wraps and increments every cycle, including in OWNED.
REQ-027 With LED_ARBITER_HEARTBEAT_EN defined: IDLE drives led = heartbeat[BITS-1:BITS-8].
REQ-028 Without LED_ARBITER_HEARTBEAT_EN: the counter is absent and IDLE drives led = 8'h00.

Structure
REQ-029 Package led_arbiter_pkg holds the LED_W=8 constant and the state enum {IDLE, OWNED}.
REQ-030 Sub-module led_heartbeat (clk, rst_n, count[BITS-1:0]) is instantiated only under LED_ARBITER_HEARTBEAT_EN.
REQ-031 Round-robin selection is a combinational function inside led_arbiter; it is not a separate module.

Verification (N_REQ=4, HOLD_CYCLES=4, BITS=8)
REQ-032 Stimulus: rst_n low, then release with req=0 -> grant=0; led=0; with HEARTBEAT_EN, led increments by 1 per cycle after release.
REQ-033 Stimulus: req=0001, data0=8'hA5 -> 1 cycle later grant=0001 and led=A5; grant holds while req0 stays high.
REQ-034 Stimulus: req=0011 held -> grant sequence 0001 (4 cycles), 0010 (4 cycles), 0001; no cycle with grant=0.
REQ-035 Stimulus: req0 pulses 1 cycle, data0=8'h3C -> led=3C and grant=0001 for 4 cycles, then IDLE.
REQ-036 Stimulus: owner=2, then req=1001 at hold=0 -> next grant=1000 (wrap search from 3), then 0001.
REQ-037 Stimulus: rst_n asserted mid-OWNED -> grant=0 and led=0 immediately, asynchronous to clk.

Source files
------------

// File: rtl/led_arbiter_pkg.sv
// Shared constants and state encoding for the LED bank arbiter.
package led_arbiter_pkg;

  localparam int LED_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

endpackage

// File: rtl/led_heartbeat.sv
// Free-running idle-display counter; only present when LED_ARBITER_HEARTBEAT_EN is defined.
`ifdef LED_ARBITER_HEARTBEAT_EN
module led_heartbeat #(
  parameter int BITS = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [BITS-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count + BITS'(1);
  end

endmodule
`endif

// File: rtl/led_arbiter.sv
// Round-robin owner of an 8-bit LED bank with a minimum grant tenure.
// LED_ARBITER_HEARTBEAT_EN shows a heartbeat counter on the LEDs while idle; otherwise idle LEDs are dark.
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int BITS        = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [LED_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       grant,
  output logic [LED_W-1:0]       led
);

  localparam int                IDX_W       = $clog2(N_REQ);
  localparam int                HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0    = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("led_arbiter: N_REQ must be 2..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("led_arbiter: HOLD_CYCLES must be >= 1");
  end
  if (BITS < LED_W) begin : g_bad_bits
    $error("led_arbiter: BITS must be >= 8");
  end

  // First set bit of r, searching upward from start with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] pos;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(start) + k) % N_REQ);
      if (r[pos]) pick = pos;
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'((int'(idx) + 1) % N_REQ);
  endfunction

  logic [LED_W-1:0] data_arr [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*LED_W +: LED_W];
  end

  logic [LED_W-1:0] idle_led;
`ifdef LED_ARBITER_HEARTBEAT_EN
  logic [BITS-1:0] hb_count;

  led_heartbeat #(.BITS(BITS)) u_heartbeat (
    .clk   (clk),
    .rst_n (rst_n),
    .count (hb_count)
  );

  assign idle_led = hb_count[BITS-1 -: LED_W];
`else
  assign idle_led = '0;
`endif

  state_t            state, state_next;
  logic [IDX_W-1:0]  owner, owner_next;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic [N_REQ-1:0]  grant_next;
  logic [LED_W-1:0]  led_next;

  logic [N_REQ-1:0]  others;
  logic [IDX_W-1:0]  pick_any, pick_other;

  // rr_ptr always sits at owner+1 while OWNED, so the same search start
  // yields "next requester after the owner" once the owner is masked out.
  assign others     = req & ~grant;
  assign pick_any   = rr_pick(req, rr_ptr);
  assign pick_other = rr_pick(others, rr_ptr);

  // NOTE: every next-state variable gets its hold value first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    rr_ptr_next = rr_ptr;
    hold_next   = hold;
    grant_next  = grant;
    led_next    = led;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_next  = OWNED;
          owner_next  = pick_any;
          rr_ptr_next = next_idx(pick_any);
          hold_next   = HOLD_RELOAD;
          grant_next  = ONE_HOT0 << pick_any;
          led_next    = data_arr[pick_any];
        end else begin
          led_next = idle_led;
        end
      end
      OWNED: begin
        if (hold != '0) begin
          hold_next = hold - HOLD_W'(1);
          if (req[owner]) led_next = data_arr[owner];
        end else if (|others) begin
          owner_next  = pick_other;
          rr_ptr_next = next_idx(pick_other);
          hold_next   = HOLD_RELOAD;
          grant_next  = ONE_HOT0 << pick_other;
          led_next    = data_arr[pick_other];
        end else if (req[owner]) begin
          led_next = data_arr[owner];
        end else begin
          state_next = IDLE;
          grant_next = '0;
          led_next   = idle_led;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      hold   <= '0;
      grant  <= '0;
      led    <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_ptr <= rr_ptr_next;
      hold   <= hold_next;
      grant  <= grant_next;
      led    <= led_next;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter (N_REQ=4, HOLD_CYCLES=4, BITS=8) against a tenure-count model.
module tb_led_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [7:0]     data_b [N];
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic [7:0]     led;

  int errors = 0;
  int checks = 0;

  // Reference model: owner index (-1 = idle) and cycles owned so far.
  int         m_owner;
  int         m_tenure;
  int         m_ptr;
  int         m_hb;
  logic [7:0] m_led;

  assign req_data = {data_b[3], data_b[2], data_b[1], data_b[0]};

  always #5 clk = ~clk;

  led_arbiter #(
    .N_REQ       (N),
    .HOLD_CYCLES (HOLD),
    .BITS        (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .led      (led)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_ptr    = 0;
    m_hb     = 0;
    m_led    = 8'h00;
  endtask

  task automatic model_grant(input int who);
    m_owner  = who;
    m_tenure = 1;
    m_ptr    = (who + 1) % N;
    m_led    = data_b[who];
  endtask

  task automatic model_edge();
    logic [7:0] idle_v;
    int         pick;
    idle_v = 8'h00;
`ifdef LED_ARBITER_HEARTBEAT_EN
    idle_v = 8'(m_hb);
    m_hb   = (m_hb + 1) % 256;
`endif
    if (m_owner < 0) begin
      pick = rr_first(req, m_ptr, -1);
      if (pick >= 0) model_grant(pick);
      else           m_led = idle_v;
    end else if (m_tenure < HOLD) begin
      m_tenure++;
      if (req[m_owner]) m_led = data_b[m_owner];
    end else begin
      pick = rr_first(req, (m_owner + 1) % N, m_owner);
      if (pick >= 0)         model_grant(pick);
      else if (req[m_owner]) m_led = data_b[m_owner];
      else begin
        m_owner = -1;
        m_led   = idle_v;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("led", 32'(led), 32'(m_led));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) data_b[i] = 8'h00;
    model_reset();

    // Reset state, then idle display with no requests.
    #2;
    chk("async_reset_grant", 32'(grant), 32'd0);
    chk("async_reset_led", 32'(led), 32'd0);
    reset_dut();
    repeat (4) step();

    // Single requester acquires in one cycle and keeps the bank; led tracks its data.
    req       = 4'b0001;
    data_b[0] = 8'hA5;
    step();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_led", 32'(led), 32'hA5);
    for (int c = 0; c < 8; c++) begin
      data_b[0] = 8'(8'h10 + c);
      step();
      chk("persist_grant", 32'(grant), 32'h1);
    end
    req = '0;
    repeat (6) step();

    // Two persistent requesters alternate every HOLD cycles with no idle gap.
    req       = 4'b0011;
    data_b[0] = 8'h11;
    data_b[1] = 8'h22;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      step();
      chk("rr_seq", 32'(grant), (c < 4 || c >= 8) ? 32'h1 : 32'h2);
    end

    // One-cycle pulse: frozen pattern for the full tenure, then idle; acquired right after reset release.
    req       = 4'b0001;
    data_b[0] = 8'h3C;
    reset_dut();
    chk("post_release_grant", 32'(grant), 32'd0);
    step();
    chk("pulse_grant", 32'(grant), 32'h1);
    req       = '0;
    data_b[0] = 8'h99;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("pulse_hold_led", 32'(led), 32'h3C);
      chk("pulse_hold_grant", 32'(grant), 32'h1);
    end
    step();
    chk("pulse_release", 32'(grant), 32'd0);

    // Hand-over from owner 2 wraps the search from 3, then on to 0.
    req = 4'b0100;
    for (int i = 0; i < N; i++) data_b[i] = 8'($urandom);
    reset_dut();
    repeat (4) step();
    chk("owner2", 32'(grant), 32'h4);
    req = 4'b1001;
    step();
    chk("wrap_to_3", 32'(grant), 32'h8);
    repeat (3) step();
    step();
    chk("wrap_to_0", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      for (int i = 0; i < N; i++) data_b[i] = 8'($urandom);
      step();
    end

    // Reset mid-tenure clears outputs without a clock edge.
    req = 4'b0001;
    reset_dut();
    step();
    step();
    chk("owned_before_reset", 32'(grant), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_drop_grant", 32'(grant), 32'd0);
    chk("async_drop_led", 32'(led), 32'd0);
    reset_dut();
    req = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
